// File: rtl/dm_wait.sv
// Handshaked big-endian MIPS data memory with a programmable wait-state counter.
// Define DM_ALIGN_EXC_EN to flag misaligned half/word accesses through err.
module dm_wait #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 0,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  dm_op,
  output logic        ready,
  output logic        busy,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int AW    = ADDR_W + 2;

  localparam logic [2:0] DM_OP_WD = 3'd0;
  localparam logic [2:0] DM_OP_BS = 3'd1;
  localparam logic [2:0] DM_OP_BZ = 3'd2;
  localparam logic [2:0] DM_OP_HS = 3'd3;
  localparam logic [2:0] DM_OP_HZ = 3'd4;
  localparam logic [2:0] DM_OP_SB = 3'd5;
  localparam logic [2:0] DM_OP_SH = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        op_q, op_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [31:0]       mem [DEPTH];

  logic              cur_we;
  logic [AW-1:0]     cur_addr;
  logic [31:0]       cur_wdata;
  logic [2:0]        cur_op;
  logic [ADDR_W-1:0] widx;
  logic [31:0]       rd_word, wr_word, res_rdata;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic              commit, do_write, res_err, align_err;
  logic              valid_load, valid_store;
  logic              addr_unused;

  assign addr_unused = ^addr[31:AW];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: if (req) begin
        we_d    = we;
        addr_d  = addr[AW-1:0];
        wdata_d = wdata;
        op_d    = dm_op;
        cnt_d   = CNT_W'(WAIT_CYCLES);
        state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // With zero wait states the access resolves on the accepting edge, so use the live inputs.
  assign cur_we    = (state_q == S_IDLE) ? we            : we_q;
  assign cur_addr  = (state_q == S_IDLE) ? addr[AW-1:0]  : addr_q;
  assign cur_wdata = (state_q == S_IDLE) ? wdata         : wdata_q;
  assign cur_op    = (state_q == S_IDLE) ? dm_op         : op_q;
  assign commit    = (state_d == S_RESP) && (state_q != S_RESP);

  assign widx    = cur_addr[AW-1:2];
  assign rd_word = mem[widx];
  assign lane_h  = cur_addr[1] ? rd_word[15:0] : rd_word[31:16];

  always_comb begin
    lane_b = rd_word[7:0];
    case (cur_addr[1:0])
      2'd0: lane_b = rd_word[31:24];
      2'd1: lane_b = rd_word[23:16];
      2'd2: lane_b = rd_word[15:8];
      2'd3: lane_b = rd_word[7:0];
      default: lane_b = rd_word[7:0];
    endcase
  end

  assign valid_load  = !cur_we && (cur_op == DM_OP_WD || cur_op == DM_OP_BS ||
                       cur_op == DM_OP_BZ || cur_op == DM_OP_HS || cur_op == DM_OP_HZ);
  assign valid_store = cur_we && (cur_op == DM_OP_WD || cur_op == DM_OP_SB ||
                       cur_op == DM_OP_SH);

`ifdef DM_ALIGN_EXC_EN
  always_comb begin
    align_err = 1'b0;
    if (valid_load || valid_store) begin
      if (cur_op == DM_OP_HS || cur_op == DM_OP_HZ || cur_op == DM_OP_SH)
        align_err = cur_addr[0];
      else if (cur_op == DM_OP_WD)
        align_err = (cur_addr[1:0] != 2'd0);
    end
  end
`else
  assign align_err = 1'b0;
`endif

  always_comb begin
    res_rdata = 32'd0;
    res_err   = 1'b0;
    do_write  = 1'b0;
    wr_word   = rd_word;
    if (align_err) begin
      res_err = 1'b1;
    end else if (valid_load) begin
      case (cur_op)
        DM_OP_WD: res_rdata = rd_word;
        DM_OP_BS: res_rdata = {{24{lane_b[7]}}, lane_b};
        DM_OP_BZ: res_rdata = {24'd0, lane_b};
        DM_OP_HS: res_rdata = {{16{lane_h[15]}}, lane_h};
        DM_OP_HZ: res_rdata = {16'd0, lane_h};
        default:  res_rdata = 32'd0;
      endcase
    end else if (valid_store) begin
      do_write = 1'b1;
      case (cur_op)
        DM_OP_SB: case (cur_addr[1:0])
          2'd0:    wr_word[31:24] = cur_wdata[7:0];
          2'd1:    wr_word[23:16] = cur_wdata[7:0];
          2'd2:    wr_word[15:8]  = cur_wdata[7:0];
          default: wr_word[7:0]   = cur_wdata[7:0];
        endcase
        DM_OP_SH: if (cur_addr[1]) wr_word[15:0]  = cur_wdata[15:0];
                  else             wr_word[31:16] = cur_wdata[15:0];
        default:  wr_word = cur_wdata;
      endcase
    end
  end

  assign rdata_d = commit ? res_rdata : rdata_q;
  assign err_d   = commit ? res_err   : err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the array has no reset so it maps onto RAM; rst_n only blocks a write during reset.
  always_ff @(posedge clk) begin
    if (rst_n && commit && do_write) mem[widx] <= wr_word;
  end

  assign ready = (state_q == S_RESP);
  assign busy  = (state_q != S_IDLE);
  assign rdata = rdata_q;
  assign err   = err_q;

endmodule
